mac_reg_arbiter: RTL

//  Round-robin arbiter that shares the single MAC register access port among NUM_REQ

---
 rtl/mac_reg_arbiter_if.sv | 32 +++
 rtl/mac_reg_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mac_reg_arbiter_if.sv
// Bundle of requester-side and sequencer-side signals for mac_reg_arbiter.
// The slave modport is the arbiter view; the master modport is the requester/sequencer environment view.
interface mac_reg_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    i_req;
    logic [NUM_REQ-1:0]    i_rdwn;
    logic [14*NUM_REQ-1:0] i_addr;
    logic [32*NUM_REQ-1:0] i_wr_data;
    logic [NUM_REQ-1:0]    o_done;
    logic [NUM_REQ-1:0]    o_err;
    logic [31:0]           o_rd_data;
    logic [NUM_REQ-1:0]    o_grant;
    logic                  o_mac_request;
    logic                  o_mac_rdwn;
    logic [13:0]           o_mac_addr;
    logic [31:0]           o_mac_wr_data;
    logic                  i_mac_done;
    logic [31:0]           i_mac_rd_data;

    modport slave (
        input  i_req, i_rdwn, i_addr, i_wr_data, i_mac_done, i_mac_rd_data,
        output o_done, o_err, o_rd_data, o_grant,
        output o_mac_request, o_mac_rdwn, o_mac_addr, o_mac_wr_data
    );

    modport master (
        output i_req, i_rdwn, i_addr, i_wr_data, i_mac_done, i_mac_rd_data,
        input  o_done, o_err, o_rd_data, o_grant,
        input  o_mac_request, o_mac_rdwn, o_mac_addr, o_mac_wr_data
    );
endinterface

// File: rtl/mac_reg_arbiter.sv
// Round-robin arbiter sharing one MAC register access port among NUM_REQ requesters.
// Optional WAIT timeout is enabled with the MAC_REG_ARB_TIMEOUT_EN macro.
module mac_reg_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic               i_clk,
    input  logic               i_rst,
    mac_reg_arbiter_if.slave   bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input int unsigned        off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= 32'(NUM_REQ)) begin
            sum = sum - 32'(NUM_REQ);
        end else begin
            sum = sum;
        end
        return sum[IDX_W-1:0];
    endfunction

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    gidx_q, gidx_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic                mac_request_q, mac_request_d;
    logic                mac_rdwn_q, mac_rdwn_d;
    logic [13:0]         mac_addr_q, mac_addr_d;
    logic [31:0]         mac_wr_data_q, mac_wr_data_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic [31:0]         rd_data_q, rd_data_d;
`ifdef MAC_REG_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    logic [NUM_REQ-1:0]  err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

    logic                win_found_s;
    logic [IDX_W-1:0]    win_idx_s;
    logic [IDX_W-1:0]    cand_s;

    // Round-robin winner: first active request scanning upward from ptr, wrapping.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = {IDX_W{1'b0}};
        cand_s      = {IDX_W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_s = wrap_add(ptr_q, 32'(i));
            if (!win_found_s && bus.i_req[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Next-state and registered-output computation for the transaction FSM.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        gidx_d        = gidx_q;
        grant_d       = grant_q;
        mac_request_d = 1'b0;
        mac_rdwn_d    = mac_rdwn_q;
        mac_addr_d    = mac_addr_q;
        mac_wr_data_d = mac_wr_data_q;
        done_d        = {NUM_REQ{1'b0}};
        rd_data_d     = 32'h0000_0000;
`ifdef MAC_REG_ARB_TIMEOUT_EN
        err_d         = {NUM_REQ{1'b0}};
        cnt_d         = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (win_found_s) begin
                    state_d       = ST_ISSUE;
                    gidx_d        = win_idx_s;
                    grant_d       = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx_s;
                    mac_rdwn_d    = bus.i_rdwn[win_idx_s];
                    mac_addr_d    = bus.i_addr[14*32'(win_idx_s) +: 14];
                    mac_wr_data_d = bus.i_wr_data[32*32'(win_idx_s) +: 32];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            // The request flop is loaded here, so the pulse is seen on the first WAIT cycle.
            ST_ISSUE: begin
                state_d       = ST_WAIT;
                mac_request_d = 1'b1;
`ifdef MAC_REG_ARB_TIMEOUT_EN
                cnt_d         = {CNT_W{1'b0}};
`endif
            end
            ST_WAIT: begin
                if (bus.i_mac_done) begin
                    state_d       = ST_DONE;
                    done_d        = grant_q;
                    rd_data_d     = mac_rdwn_q ? bus.i_mac_rd_data : 32'h0000_0000;
                    mac_rdwn_d    = 1'b0;
                    mac_addr_d    = 14'h0000;
                    mac_wr_data_d = 32'h0000_0000;
                end else begin
`ifdef MAC_REG_ARB_TIMEOUT_EN
                    if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                        state_d       = ST_DONE;
                        done_d        = grant_q;
                        err_d         = grant_q;
                        mac_rdwn_d    = 1'b0;
                        mac_addr_d    = 14'h0000;
                        mac_wr_data_d = 32'h0000_0000;
                    end else begin
                        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
`else
                    state_d = ST_WAIT;
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                grant_d = {NUM_REQ{1'b0}};
                ptr_d   = wrap_add(gidx_q, 32'd1);
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = {NUM_REQ{1'b0}};
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= ST_IDLE;
            ptr_q         <= {IDX_W{1'b0}};
            gidx_q        <= {IDX_W{1'b0}};
            grant_q       <= {NUM_REQ{1'b0}};
            mac_request_q <= 1'b0;
            mac_rdwn_q    <= 1'b0;
            mac_addr_q    <= 14'h0000;
            mac_wr_data_q <= 32'h0000_0000;
            done_q        <= {NUM_REQ{1'b0}};
            rd_data_q     <= 32'h0000_0000;
`ifdef MAC_REG_ARB_TIMEOUT_EN
            err_q         <= {NUM_REQ{1'b0}};
            cnt_q         <= {CNT_W{1'b0}};
`endif
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            gidx_q        <= gidx_d;
            grant_q       <= grant_d;
            mac_request_q <= mac_request_d;
            mac_rdwn_q    <= mac_rdwn_d;
            mac_addr_q    <= mac_addr_d;
            mac_wr_data_q <= mac_wr_data_d;
            done_q        <= done_d;
            rd_data_q     <= rd_data_d;
`ifdef MAC_REG_ARB_TIMEOUT_EN
            err_q         <= err_d;
            cnt_q         <= cnt_d;
`endif
        end
    end

    assign bus.o_grant       = grant_q;
    assign bus.o_mac_request = mac_request_q;
    assign bus.o_mac_rdwn    = mac_rdwn_q;
    assign bus.o_mac_addr    = mac_addr_q;
    assign bus.o_mac_wr_data = mac_wr_data_q;
    assign bus.o_done        = done_q;
    assign bus.o_rd_data     = rd_data_q;
`ifdef MAC_REG_ARB_TIMEOUT_EN
    assign bus.o_err         = err_q;
`else
    assign bus.o_err         = {NUM_REQ{1'b0}};
`endif

endmodule
